// File: rtl/dff_using_sr_jk_t.sv
// rtl/dff_using_sr_jk_t.sv - D flip-flop built three ways (SR, JK, T) per bit lane.
// Optional DFF_XCHECK_EN adds a sticky mismatch flag comparing the three paths.
module dff_using_sr_jk_t #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q_sr,
  output logic [WIDTH-1:0] Q_jk,
`ifdef DFF_XCHECK_EN
  output logic [WIDTH-1:0] Q_t,
  output logic             mismatch
`else
  output logic [WIDTH-1:0] Q_t
`endif
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] jk_q, jk_d;
  logic [WIDTH-1:0] t_q,  t_d;
  logic [WIDTH-1:0] s, r, j, k, t;

  always_comb begin
    s    = D;
    r    = ~D;
    j    = D;
    k    = ~D;
    t    = D ^ t_q;
    sr_d = sr_q;
    jk_d = jk_q;
    t_d  = t_q;
    for (int i = 0; i < WIDTH; i++) begin
      // S=R=1 is unreachable with R=~S; it holds rather than guessing a value.
      case ({s[i], r[i]})
        2'b10:   sr_d[i] = 1'b1;
        2'b01:   sr_d[i] = 1'b0;
        default: sr_d[i] = sr_q[i];
      endcase
      case ({j[i], k[i]})
        2'b10:   jk_d[i] = 1'b1;
        2'b01:   jk_d[i] = 1'b0;
        2'b11:   jk_d[i] = ~jk_q[i];
        default: jk_d[i] = jk_q[i];
      endcase
      t_d[i] = t_q[i] ^ t[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= RESET_VALUE;
      jk_q <= RESET_VALUE;
      t_q  <= RESET_VALUE;
    end else begin
      sr_q <= sr_d;
      jk_q <= jk_d;
      t_q  <= t_d;
    end
  end

  assign Q_sr = sr_q;
  assign Q_jk = jk_q;
  assign Q_t  = t_q;

`ifdef DFF_XCHECK_EN
  logic mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q | (|((sr_q ^ jk_q) | (sr_q ^ t_q)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_dff_using_sr_jk_t.sv
// tb/tb_dff_using_sr_jk_t.sv - scoreboard bench for dff_using_sr_jk_t (1-lane and 4-lane builds).
module tb_dff_using_sr_jk_t;

  typedef struct {
    logic [0:0] d_a;
    logic [3:0] d_b;
    logic [0:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  typedef struct {
    logic [0:0] exp_a;
    logic [3:0] exp_b;
  } sb_t;

  logic       clk;
  logic       reset;
  logic [0:0] d_a;
  logic [3:0] d_b;
  logic [0:0] q_sr_a, q_jk_a, q_t_a;
  logic [3:0] q_sr_b, q_jk_b, q_t_b;
`ifdef DFF_XCHECK_EN
  logic       mm_a, mm_b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  sb_t sb_q[$];
  vec_t vecs[6];

  dff_using_sr_jk_t #(.WIDTH(1)) dut_a (
    .clk(clk), .reset(reset), .D(d_a),
    .Q_sr(q_sr_a), .Q_jk(q_jk_a),
`ifdef DFF_XCHECK_EN
    .Q_t(q_t_a), .mismatch(mm_a)
`else
    .Q_t(q_t_a)
`endif
  );

  dff_using_sr_jk_t #(.WIDTH(4), .RESET_VALUE(4'hA)) dut_b (
    .clk(clk), .reset(reset), .D(d_b),
    .Q_sr(q_sr_b), .Q_jk(q_jk_b),
`ifdef DFF_XCHECK_EN
    .Q_t(q_t_b), .mismatch(mm_b)
`else
    .Q_t(q_t_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [0:0] ea, input logic [3:0] eb);
    check({tag, " a.Q_sr"}, {3'b0, q_sr_a}, {3'b0, ea});
    check({tag, " a.Q_jk"}, {3'b0, q_jk_a}, {3'b0, ea});
    check({tag, " a.Q_t"},  {3'b0, q_t_a},  {3'b0, ea});
    check({tag, " b.Q_sr"}, q_sr_b, eb);
    check({tag, " b.Q_jk"}, q_jk_b, eb);
    check({tag, " b.Q_t"},  q_t_b,  eb);
  endtask

  task automatic pop_check(input string tag);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_all(tag, e.exp_a, e.exp_b);
    end
  endtask

  // Checks the value captured at this edge, then drives the next D 1 ns after it.
  task automatic apply(input string tag, input logic [0:0] da, input logic [3:0] db,
                       input logic [0:0] ea, input logic [3:0] eb);
    sb_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) pop_check(tag);
    d_a = da;
    d_b = db;
    e.exp_a = ea;
    e.exp_b = eb;
    sb_q.push_back(e);
  endtask

  task automatic flush(input string tag);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    sb_t e;
    vecs[0] = '{1'b0, 4'h3, 1'b0, 4'h3};
    vecs[1] = '{1'b1, 4'hC, 1'b1, 4'hC};
    vecs[2] = '{1'b0, 4'h0, 1'b0, 4'h0};
    vecs[3] = '{1'b1, 4'hF, 1'b1, 4'hF};
    vecs[4] = '{1'b1, 4'h9, 1'b1, 4'h9};
    vecs[5] = '{1'b0, 4'h6, 1'b0, 4'h6};

    reset = 1'b1;
    d_a   = 1'b1;
    d_b   = 4'h5;
    #2 reset = 1'b0;
    #1 check_all("async_reset", 1'b0, 4'hA);
`ifdef DFF_XCHECK_EN
    check("reset mm_a", {3'b0, mm_a}, 4'h0);
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all("in_reset", 1'b0, 4'hA);
    end

    // Release between edges with D already set; the next edge must capture it.
    reset = 1'b1;
    e.exp_a = 1'b1;
    e.exp_b = 4'h5;
    sb_q.push_back(e);
    flush("first_edge");
`ifdef DFF_XCHECK_EN
    check("first_edge mm_a", {3'b0, mm_a}, 4'h0);
    check("first_edge mm_b", {3'b0, mm_b}, 4'h0);
`endif

    foreach (vecs[i]) apply("capture", vecs[i].d_a, vecs[i].d_b, vecs[i].exp_a, vecs[i].exp_b);
    flush("capture");

    for (int i = 0; i < 3; i++) apply("hold", 1'b1, 4'hB, 1'b1, 4'hB);
    flush("hold");

    // Outputs are 1/B here; reset lands 3 ns after the edge.
    #2 reset = 1'b0;
    #1 check_all("mid_reset", 1'b0, 4'hA);
    @(negedge clk);
    check_all("mid_reset_hold", 1'b0, 4'hA);
    d_a = 1'b1;
    d_b = 4'h5;
    reset = 1'b1;
    e.exp_a = 1'b1;
    e.exp_b = 4'h5;
    sb_q.push_back(e);
    flush("after_mid_reset");

    for (int i = 0; i < 1000; i++) begin
      logic [0:0] ra;
      logic [3:0] rb;
      ra = 1'($urandom_range(0, 1));
      rb = 4'($urandom_range(0, 15));
      apply("random", ra, rb, ra, rb);
    end
    flush("random");
`ifdef DFF_XCHECK_EN
    check("final mm_a", {3'b0, mm_a}, 4'h0);
    check("final mm_b", {3'b0, mm_b}, 4'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
